difftest_trap_collector: RTL and testbench

DIFFTEST_TRAP_COLLECTOR -- requirements
Module: difftest_trap_collector

---
 rtl/difftest_trap_pkg.sv | 27 ++
 rtl/difftest_trap_rr_arbiter.sv | 42 ++++
 rtl/difftest_trap_collector.sv | 167 ++++++++++++++++
 tb/tb_difftest_trap_collector.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_trap_pkg.sv
// Shared trap codes, slot-entry layout and sizing helper for the difftest trap collector.
// Optional WFI support is enabled by defining DIFFTEST_TRAP_WFI_EN.
package difftest_trap_pkg;

  localparam logic [2:0] TRAP_GOOD  = 3'd0;
  localparam logic [2:0] TRAP_BAD   = 3'd1;
  localparam logic [2:0] TRAP_ABORT = 3'd2;

  // PCs are stored at full width; the top truncates to XLEN on output.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic                has_trap;
`ifdef DIFFTEST_TRAP_WFI_EN
    logic                has_wfi;
`endif
    logic [2:0]          code;
    logic [PC_MAX_W-1:0] pc;
    logic [63:0]         instr_cnt;
    logic [63:0]         cycle_cnt;
  } slot_entry_t;

  function automatic int cid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/difftest_trap_rr_arbiter.sv
// Round-robin grant over per-core FULL slots; the pointer moves past a grant only
// when that grant is actually consumed (advance).
module difftest_trap_rr_arbiter
  import difftest_trap_pkg::*;
#(
  parameter int NUM_CORES = 2,
  localparam int CID_W = cid_width(NUM_CORES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 advance,
  output logic                 gnt_valid,
  output logic [CID_W-1:0]     gnt_idx
);

  logic [CID_W-1:0] ptr;
  logic [CID_W-1:0] cand;

  // Scan offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = CID_W'((int'(ptr) + i) % NUM_CORES);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && gnt_valid) begin
      ptr <= (gnt_idx == CID_W'(NUM_CORES - 1)) ? '0 : gnt_idx + CID_W'(1);
    end
  end

endmodule

// File: rtl/difftest_trap_collector.sv
// Collects per-core difftest trap events into one-deep slots and serialises them
// through a round-robin arbiter into a single registered valid/ready output stage.
// Optional WFI ports are added when DIFFTEST_TRAP_WFI_EN is defined.
module difftest_trap_collector
  import difftest_trap_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int XLEN = 64,
  localparam int CID_W = cid_width(NUM_CORES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      io_in_valid,
  input  logic [NUM_CORES-1:0]      io_in_hasTrap,
`ifdef DIFFTEST_TRAP_WFI_EN
  input  logic [NUM_CORES-1:0]      io_in_hasWFI,
`endif
  input  logic [3*NUM_CORES-1:0]    io_in_code,
  input  logic [XLEN*NUM_CORES-1:0] io_in_pc,
  input  logic [64*NUM_CORES-1:0]   io_in_instrCnt,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [CID_W-1:0]          io_out_coreid,
  output logic                      io_out_hasTrap,
`ifdef DIFFTEST_TRAP_WFI_EN
  output logic                      io_out_hasWFI,
`endif
  output logic [2:0]                io_out_code,
  output logic [XLEN-1:0]           io_out_pc,
  output logic [63:0]               io_out_instrCnt,
  output logic [63:0]               io_out_cycleCnt,
  output logic [NUM_CORES-1:0]      io_overflow,
  output logic                      io_allTrapped
);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  // Valid/ready: an event transfers on a rising edge where io_out_valid and
  // io_out_ready are both high; while valid is high and ready low, all io_out_*
  // fields hold their value.

  logic [63:0]          cycle_cnt;
  logic [0:0]           slot_state [NUM_CORES];
  slot_entry_t          slot_q     [NUM_CORES];
  slot_entry_t          in_entry   [NUM_CORES];
  logic [NUM_CORES-1:0] slot_full;
  logic [NUM_CORES-1:0] drain;
  logic [NUM_CORES-1:0] trapped;
  logic [NUM_CORES-1:0] overflow;
  logic                 gnt_valid;
  logic [CID_W-1:0]     gnt_idx;
  logic                 load_en;
  logic                 handshake;
  logic                 out_valid;
  logic [CID_W-1:0]     out_coreid;
  slot_entry_t          out_entry;

  function automatic logic can_replace(input slot_entry_t held, input slot_entry_t incoming);
`ifdef DIFFTEST_TRAP_WFI_EN
    return incoming.has_trap && !incoming.has_wfi && !held.has_trap;
`else
    return incoming.has_trap && !held.has_trap;
`endif
  endfunction

  assign handshake = out_valid && io_out_ready;
  assign load_en   = !out_valid || io_out_ready;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      in_entry[i]           = '0;
      in_entry[i].has_trap  = io_in_hasTrap[i];
`ifdef DIFFTEST_TRAP_WFI_EN
      in_entry[i].has_wfi   = io_in_hasWFI[i];
`endif
      in_entry[i].code      = io_in_code[3*i +: 3];
      in_entry[i].pc        = PC_MAX_W'(io_in_pc[XLEN*i +: XLEN]);
      in_entry[i].instr_cnt = io_in_instrCnt[64*i +: 64];
      in_entry[i].cycle_cnt = cycle_cnt;
      slot_full[i]          = (slot_state[i] == SLOT_FULL);
      drain[i]              = load_en && gnt_valid && (gnt_idx == CID_W'(i));
    end
  end

  difftest_trap_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (slot_full),
    .advance   (load_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // A slot being drained this cycle counts as free for a same-cycle arrival.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot_state[i] <= SLOT_EMPTY;
        slot_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (io_in_valid[i] && (slot_state[i] == SLOT_EMPTY || drain[i])) begin
          slot_q[i]     <= in_entry[i];
          slot_state[i] <= SLOT_FULL;
        end else if (io_in_valid[i]) begin
          overflow[i] <= 1'b1;
          if (can_replace(slot_q[i], in_entry[i])) begin
            slot_q[i] <= in_entry[i];
          end
        end else if (drain[i]) begin
          slot_state[i] <= SLOT_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_coreid <= '0;
      out_entry  <= '0;
    end else if (load_en) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_coreid <= gnt_idx;
        out_entry  <= slot_q[gnt_idx];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trapped <= '0;
    end else if (handshake && out_entry.has_trap) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (out_coreid == CID_W'(i)) begin
          trapped[i] <= 1'b1;
        end
      end
    end
  end

  assign io_out_valid    = out_valid;
  assign io_out_coreid   = out_coreid;
  assign io_out_hasTrap  = out_entry.has_trap;
`ifdef DIFFTEST_TRAP_WFI_EN
  assign io_out_hasWFI   = out_entry.has_wfi;
`endif
  assign io_out_code     = out_entry.code;
  assign io_out_pc       = out_entry.pc[XLEN-1:0];
  assign io_out_instrCnt = out_entry.instr_cnt;
  assign io_out_cycleCnt = out_entry.cycle_cnt;
  assign io_overflow     = overflow;
  assign io_allTrapped   = &trapped;

endmodule

// File: tb/tb_difftest_trap_collector.sv
// Directed scoreboard bench for difftest_trap_collector (NUM_CORES=2, XLEN=64).
module tb_difftest_trap_collector;
  import difftest_trap_pkg::*;

  localparam int NUM_CORES = 2;
  localparam int XLEN = 64;
  localparam int CID_W = 1;
  localparam int EW = CID_W + 1 + 3 + 64 + 64 + 64;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_CORES-1:0]      io_in_valid = '0;
  logic [NUM_CORES-1:0]      io_in_hasTrap = '0;
  logic [3*NUM_CORES-1:0]    io_in_code = '0;
  logic [XLEN*NUM_CORES-1:0] io_in_pc = '0;
  logic [64*NUM_CORES-1:0]   io_in_instrCnt = '0;
  logic                      io_out_valid;
  logic                      io_out_ready = 1'b0;
  logic [CID_W-1:0]          io_out_coreid;
  logic                      io_out_hasTrap;
  logic [2:0]                io_out_code;
  logic [XLEN-1:0]           io_out_pc;
  logic [63:0]               io_out_instrCnt;
  logic [63:0]               io_out_cycleCnt;
  logic [NUM_CORES-1:0]      io_overflow;
  logic                      io_allTrapped;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0] tb_cyc = '0;

  difftest_trap_collector #(.NUM_CORES(NUM_CORES), .XLEN(XLEN)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_hasTrap   (io_in_hasTrap),
    .io_in_code      (io_in_code),
    .io_in_pc        (io_in_pc),
    .io_in_instrCnt  (io_in_instrCnt),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_coreid   (io_out_coreid),
    .io_out_hasTrap  (io_out_hasTrap),
    .io_out_code     (io_out_code),
    .io_out_pc       (io_out_pc),
    .io_out_instrCnt (io_out_instrCnt),
    .io_out_cycleCnt (io_out_cycleCnt),
    .io_overflow     (io_overflow),
    .io_allTrapped   (io_allTrapped)
  );

  // Clock and reference cycle count (stamp model).
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  function automatic logic [EW-1:0] pack(input logic [CID_W-1:0] cid, input logic trap,
                                         input logic [2:0] code, input logic [63:0] pc,
                                         input logic [63:0] icnt, input logic [63:0] cyc);
    return {cid, trap, code, pc, icnt, cyc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: the main flow always sits 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    io_in_valid = '0;
  endtask

  task automatic put(input int core, input logic trap, input logic [2:0] code,
                     input logic [63:0] pc, input logic [63:0] icnt, input bit expect_out);
    io_in_valid[core]             = 1'b1;
    io_in_hasTrap[core]           = trap;
    io_in_code[3*core +: 3]       = code;
    io_in_pc[XLEN*core +: XLEN]   = pc;
    io_in_instrCnt[64*core +: 64] = icnt;
    if (expect_out) exp_q.push_back(pack(CID_W'(core), trap, code, pc, icnt, tb_cyc));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    io_in_valid  = '0;
    io_out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  logic          stall_prev = 1'b0;
  logic [EW-1:0] held_val = '0;
  always @(negedge clock) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] exp;
    cur = pack(io_out_coreid, io_out_hasTrap, io_out_code, io_out_pc, io_out_instrCnt, io_out_cycleCnt);
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && io_out_valid) begin
        n_checks++;
        if (cur !== held_val) begin
          n_errors++;
          $display("FAIL stall_hold: got %h expected %h", cur, held_val);
        end
      end
      if (io_out_valid && io_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL out_event: got unexpected %h expected no event", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            n_errors++;
            $display("FAIL out_event: got %h expected %h", cur, exp);
          end
        end
      end
      stall_prev = io_out_valid && !io_out_ready;
      held_val   = cur;
    end
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [63:0] stamp;
    bit found;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 64'(io_out_valid), 64'd0);
    check("rst_coreid", 64'(io_out_coreid), 64'd0);
    check("rst_hastrap", 64'(io_out_hasTrap), 64'd0);
    check("rst_code", 64'(io_out_code), 64'd0);
    check("rst_pc", io_out_pc, 64'd0);
    check("rst_icnt", io_out_instrCnt, 64'd0);
    check("rst_ccnt", io_out_cycleCnt, 64'd0);
    check("rst_overflow", 64'(io_overflow), 64'd0);
    check("rst_alltrapped", 64'(io_allTrapped), 64'd0);
    reset = 1'b0;

    // Single event, two-edge latency, stamp equals issue cycle
    step();
    step();
    io_out_ready = 1'b1;
    stamp = tb_cyc;
    put(0, 1'b0, TRAP_GOOD, 64'h8000_0000, 64'd1, 1'b1);
    step();
    check("lat_edge1_valid", 64'(io_out_valid), 64'd0);
    step();
    check("lat_edge2_valid", 64'(io_out_valid), 64'd1);
    check("lat_coreid", 64'(io_out_coreid), 64'd0);
    check("lat_ccnt", io_out_cycleCnt, stamp);
    check("lat_pc", io_out_pc, 64'h8000_0000);
    wait_drain("single");

    // Simultaneous pairs: core0 first both times
    do_reset();
    io_out_ready = 1'b1;
    put(0, 1'b0, TRAP_GOOD, 64'h8000_0100, 64'd10, 1'b1);
    put(1, 1'b0, TRAP_GOOD, 64'h9000_0100, 64'd20, 1'b1);
    step();
    wait_drain("pair1");
    put(0, 1'b0, TRAP_GOOD, 64'h8000_0200, 64'd11, 1'b1);
    put(1, 1'b0, TRAP_GOOD, 64'h9000_0200, 64'd21, 1'b1);
    step();
    wait_drain("pair2");

    // Sustained back-to-back on one core: no overflow
    put(0, 1'b0, TRAP_GOOD, 64'h8000_1000, 64'd100, 1'b1);
    step();
    put(0, 1'b0, TRAP_GOOD, 64'h8000_1004, 64'd101, 1'b1);
    step();
    put(0, 1'b0, TRAP_GOOD, 64'h8000_1008, 64'd102, 1'b1);
    step();
    wait_drain("burst");
    check("burst_overflow", 64'(io_overflow), 64'd0);

    // Trap replaces held non-trap on core1
    do_reset();
    put(0, 1'b0, TRAP_GOOD, 64'h8000_2000, 64'd5, 1'b1);
    step();
    step();
    step();
    put(1, 1'b0, TRAP_GOOD, 64'h9000_2000, 64'd6, 1'b0);
    step();
    put(1, 1'b1, TRAP_BAD, 64'h9000_2004, 64'd7, 1'b1);
    step();
    step();
    check("replace_overflow", 64'(io_overflow), 64'd2);
    io_out_ready = 1'b1;
    wait_drain("replace");
    check("replace_sticky", 64'(io_overflow), 64'd2);

    // Second non-trap on core0 dropped
    do_reset();
    put(1, 1'b0, TRAP_GOOD, 64'h9000_3000, 64'd8, 1'b1);
    step();
    step();
    step();
    put(0, 1'b0, TRAP_GOOD, 64'h8000_3000, 64'd9, 1'b1);
    step();
    put(0, 1'b0, TRAP_ABORT, 64'h8000_3004, 64'd10, 1'b0);
    step();
    step();
    check("drop_overflow", 64'(io_overflow), 64'd1);
    io_out_ready = 1'b1;
    wait_drain("drop");

    // allTrapped after core0 then core1 trap handshakes
    do_reset();
    io_out_ready = 1'b1;
    put(0, 1'b1, TRAP_GOOD, 64'h8000_4000, 64'd30, 1'b1);
    step();
    wait_drain("trap0");
    check("alltrapped_after_core0", 64'(io_allTrapped), 64'd0);
    put(1, 1'b1, TRAP_BAD, 64'h9000_4000, 64'd31, 1'b1);
    step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (io_out_valid && io_out_ready && io_out_coreid == 1'b1) found = 1'b1;
    end
    check("core1_trap_seen", 64'(found), 64'd1);
    check("alltrapped_at_hs", 64'(io_allTrapped), 64'd0);
    @(posedge clock);
    #1;
    check("alltrapped_after_hs", 64'(io_allTrapped), 64'd1);
    wait_drain("trap1");

    // Reset mid-transfer discards everything
    io_out_ready = 1'b0;
    put(0, 1'b1, TRAP_ABORT, 64'h8000_5000, 64'd40, 1'b0);
    step();
    put(1, 1'b0, TRAP_GOOD, 64'h9000_5000, 64'd41, 1'b0);
    step();
    check("pre_reset_valid", 64'(io_out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(io_out_valid), 64'd0);
    check("midrst_pc", io_out_pc, 64'd0);
    check("midrst_icnt", io_out_instrCnt, 64'd0);
    check("midrst_hastrap", 64'(io_out_hasTrap), 64'd0);
    check("midrst_alltrapped", 64'(io_allTrapped), 64'd0);
    step();
    step();
    reset = 1'b0;
    io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_reset_idle", 64'(io_out_valid), 64'd0);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
